// File: rtl/trace_pkg.sv
// Shared types for the core trace buffer: entry kinds, packed entry layout, drop counter width.
// Optional TRACE_TIMESTAMP_EN appends a 32-bit cycle stamp to every entry.
package trace_pkg;

  localparam int DROP_CNT_W   = 16;
  localparam int TRACE_ADDR_W = 9;
  localparam int TRACE_DATA_W = 32;
  localparam int STAMP_W      = 32;

  typedef enum logic [1:0] {
    KIND_REG    = 2'b00,
    KIND_MEM_WR = 2'b01,
    KIND_MEM_RD = 2'b10
  } kind_e;

  typedef struct packed {
    kind_e                    kind;
    logic [TRACE_ADDR_W-1:0]  idx;
    logic [TRACE_DATA_W-1:0]  data;
`ifdef TRACE_TIMESTAMP_EN
    logic [STAMP_W-1:0]       stamp;
`endif
  } trace_entry_t;

  // Saturating add of 0..2 dropped events onto the drop counter.
  function automatic logic [DROP_CNT_W-1:0] sat_add_drop(input logic [DROP_CNT_W-1:0] a,
                                                         input logic [1:0]            b);
    logic [DROP_CNT_W:0] s;
    s = {1'b0, a} + {{(DROP_CNT_W-1){1'b0}}, b};
    return s[DROP_CNT_W] ? {DROP_CNT_W{1'b1}} : s[DROP_CNT_W-1:0];
  endfunction

endpackage

// File: rtl/trace_fifo_mem.sv
// DEPTH x trace_entry_t storage: two write ports at consecutive slots, one combinational read port.
// Writes land at the clock edge; the read port reflects stored contents only.
module trace_fifo_mem
  import trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we0,
  input  logic [PTR_W-1:0]  i_wptr,
  input  trace_entry_t      i_wdat0,
  input  logic              i_we1,
  input  trace_entry_t      i_wdat1,
  input  logic [PTR_W-1:0]  i_rptr,
  output trace_entry_t      o_rdat
);

  trace_entry_t r_mem [DEPTH];
  logic [PTR_W-1:0] w_wptr1;

  // Second port targets the slot after the first; wraps with the pointer width.
  assign w_wptr1 = i_wptr + PTR_W'(1);

  always_ff @(posedge clk) begin
    if (i_we0) r_mem[i_wptr]  <= i_wdat0;
    if (i_we1) r_mem[w_wptr1] <= i_wdat1;
  end

  assign o_rdat = r_mem[i_rptr];

endmodule

// File: rtl/trace_event_fifo.sv
// Captures committed reg writes and mem accesses (up to 2/cycle) and drains one per cycle via valid/ready.
// Latency 1 cycle, no input-to-output path; when full, new events are dropped and counted. Option: TRACE_TIMESTAMP_EN.
module trace_event_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       reg_write_sig,
  input  logic [4:0]                 reg_num,
  input  logic [DATA_W-1:0]          reg_data,
  input  logic                       wr,
  input  logic                       rd,
  input  logic [ADDR_W-1:0]          addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [DATA_W-1:0]          rd_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output kind_e                      out_kind,
  output logic [ADDR_W-1:0]          out_idx,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic [DROP_CNT_W-1:0]      drop_cnt,
`ifdef TRACE_TIMESTAMP_EN
  output logic [STAMP_W-1:0]         out_cycle,
`endif
  output logic                       conflict
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]      r_wptr, r_rptr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_overflow, r_conflict;
  logic [DROP_CNT_W-1:0] r_drop_cnt;
`ifdef TRACE_TIMESTAMP_EN
  logic [STAMP_W-1:0]    r_cycle;
`endif

  logic                  w_pop, w_reg_ev, w_mem_ev, w_store_reg, w_store_mem;
  logic [CNT_W-1:0]      w_free;
  logic [1:0]            w_n_ev, w_n_push, w_n_drop;
  trace_entry_t          w_reg_ent, w_mem_ent, w_wdat0, w_head;

  assign w_pop    = (r_count != '0) && out_ready;
  assign w_reg_ev = reg_write_sig && (reg_num != 5'd0);
  assign w_mem_ev = wr ^ rd;

  // A same-cycle pop returns its slot to this cycle's pushes; reg has priority over mem.
  assign w_free      = CNT_W'(DEPTH) - r_count + CNT_W'(w_pop);
  assign w_store_reg = w_reg_ev && (w_free != '0);
  assign w_store_mem = w_mem_ev && (w_free > CNT_W'(w_store_reg));

  assign w_n_ev   = {1'b0, w_reg_ev} + {1'b0, w_mem_ev};
  assign w_n_push = {1'b0, w_store_reg} + {1'b0, w_store_mem};
  assign w_n_drop = w_n_ev - w_n_push;

  always_comb begin
    w_reg_ent      = '0;
    w_mem_ent      = '0;
    w_reg_ent.kind = KIND_REG;
    w_reg_ent.idx  = TRACE_ADDR_W'(reg_num);
    w_reg_ent.data = TRACE_DATA_W'(reg_data);
    w_mem_ent.kind = wr ? KIND_MEM_WR : KIND_MEM_RD;
    w_mem_ent.idx  = TRACE_ADDR_W'(addr);
    w_mem_ent.data = wr ? TRACE_DATA_W'(wr_data) : TRACE_DATA_W'(rd_data);
`ifdef TRACE_TIMESTAMP_EN
    w_reg_ent.stamp = r_cycle;
    w_mem_ent.stamp = r_cycle;
`endif
  end

  assign w_wdat0 = w_store_reg ? w_reg_ent : w_mem_ent;

  trace_fifo_mem #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk     (clk),
    .i_we0   (w_store_reg | w_store_mem),
    .i_wptr  (r_wptr),
    .i_wdat0 (w_wdat0),
    .i_we1   (w_store_reg & w_store_mem),
    .i_wdat1 (w_mem_ent),
    .i_rptr  (r_rptr),
    .o_rdat  (w_head)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_conflict <= 1'b0;
      r_drop_cnt <= '0;
`ifdef TRACE_TIMESTAMP_EN
      r_cycle    <= '0;
`endif
    end else begin
      r_wptr  <= r_wptr + PTR_W'(w_n_push);
      r_rptr  <= r_rptr + PTR_W'(w_pop);
      r_count <= r_count + CNT_W'(w_n_push) - CNT_W'(w_pop);
      if (w_n_drop != 2'd0) begin
        r_overflow <= 1'b1;
        r_drop_cnt <= sat_add_drop(r_drop_cnt, w_n_drop);
      end
      if (wr && rd) r_conflict <= 1'b1;
`ifdef TRACE_TIMESTAMP_EN
      r_cycle <= r_cycle + STAMP_W'(1);
`endif
    end
  end

  // Head fields come straight from stored flops at r_rptr; zeroed while empty so reset reads 0.
  assign out_valid = (r_count != '0);
  assign out_kind  = out_valid ? w_head.kind : KIND_REG;
  assign out_idx   = out_valid ? ADDR_W'(w_head.idx) : '0;
  assign out_data  = out_valid ? DATA_W'(w_head.data) : '0;
`ifdef TRACE_TIMESTAMP_EN
  assign out_cycle = out_valid ? w_head.stamp : '0;
`endif
  assign count     = r_count;
  assign overflow  = r_overflow;
  assign drop_cnt  = r_drop_cnt;
  assign conflict  = r_conflict;

endmodule
